// File: rtl/writeback_stage_mw.sv
// Multi-lane writeback stage: in-order write buffer draining into a WPORTS register file.
// Optional WB_FWD_EN adds a combinational lookup of pending writes.
module writeback_stage_mw #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ihit,
    input  logic                       dhit,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES-1:0]           in_wen,
    input  logic [LANES-1:0]           in_halt,
    input  logic [LANES*REG_AW-1:0]    in_wsel,
    input  logic [LANES*DATA_W-1:0]    in_wdat,
    output logic                       in_ready,
    output logic [WPORTS-1:0]          rf_wen,
    output logic [WPORTS*REG_AW-1:0]   rf_wsel,
    output logic [WPORTS*DATA_W-1:0]   rf_wdat,
    output logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0]          fwd_rsel,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] WP_C = CW'(WPORTS);
    localparam logic [CW-1:0] ROOM = CW'(DEPTH - LANES);

    logic [REG_AW-1:0] sel_q [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [AW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q, count_d;
    logic              halt_seen_q, halt_q;

    logic              acc;
    logic [LANES-1:0]  push_en;
    logic [AW-1:0]     push_off [LANES];
    logic [CW-1:0]     push_n;
    logic              older_halt;
    logic              halt_hit;
    logic [CW-1:0]     pop_n;
    logic [AW-1:0]     pidx [WPORTS];
    logic [WPORTS-1:0] pres;
    logic              unused_dhit;

    assign unused_dhit = dhit;
    assign in_ready    = (count_q <= ROOM);
    assign occupancy   = count_q;
    assign halt        = halt_q;
    assign acc = ihit & ~stall & in_ready & ~flush & ~halt_seen_q;

    // Lanes younger than a valid halt are cut off from the bundle.
    always_comb begin
        older_halt = 1'b0;
        push_n     = '0;
        push_en    = '0;
        for (int i = 0; i < LANES; i++) begin
            push_off[i] = '0;
            if (!older_halt && in_valid[i]) begin
                if (acc && in_wen[i] &&
                    in_wsel[i*REG_AW +: REG_AW] != '0) begin
                    push_en[i]  = 1'b1;
                    push_off[i] = AW'(push_n);
                    push_n      = push_n + CW'(1);
                end
                if (in_halt[i]) begin
                    older_halt = 1'b1;
                end
            end
        end
        halt_hit = acc & older_halt;
    end

    assign pop_n   = (count_q < WP_C) ? count_q : WP_C;
    assign count_d = count_q + push_n - pop_n;

    // Within one drain group only the youngest write to a register is enabled.
    always_comb begin
        for (int p = 0; p < WPORTS; p++) begin
            pidx[p] = head_q + AW'(p);
            pres[p] = (CW'(p) < count_q);
        end
        for (int p = 0; p < WPORTS; p++) begin
            rf_wen[p] = pres[p] & ~RST;
            for (int q = 0; q < WPORTS; q++) begin
                if (q > p && pres[q] && sel_q[pidx[q]] == sel_q[pidx[p]]) begin
                    rf_wen[p] = 1'b0;
                end
            end
            rf_wsel[p*REG_AW +: REG_AW] = sel_q[pidx[p]];
            rf_wdat[p*DATA_W +: DATA_W] = dat_q[pidx[p]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            head_q  <= head_q + AW'(pop_n);
            tail_q  <= tail_q + AW'(push_n);
            count_q <= count_d;
            if (halt_hit) begin
                halt_seen_q <= 1'b1;
            end
            if (halt_seen_q && count_d == '0) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_en[i]) begin
                sel_q[tail_q + push_off[i]] <= in_wsel[i*REG_AW +: REG_AW];
                dat_q[tail_q + push_off[i]] <= in_wdat[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_FWD_EN
    logic [AW-1:0] fidx;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fidx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = head_q + AW'(k);
            if (CW'(k) < count_q && fwd_rsel != '0 &&
                sel_q[fidx] == fwd_rsel) begin
                fwd_hit  = 1'b1;
                fwd_data = dat_q[fidx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage_mw.sv
// Directed self-checking bench for writeback_stage_mw.
// dut uses WPORTS=1, dut2 uses WPORTS=2 for the WAW and forwarding cases.
module tb_writeback_stage_mw;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit, dhit, stall, flush;
    logic [1:0]  in_valid, in_wen, in_halt;
    logic [9:0]  in_wsel;
    logic [63:0] in_wdat;

    logic        in_ready, halt;
    logic [0:0]  rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [2:0]  occupancy;

    logic        in_ready2, halt2;
    logic [1:0]  rf_wen2;
    logic [9:0]  rf_wsel2;
    logic [63:0] rf_wdat2;
    logic [2:0]  occ2;

    logic [4:0]  fwd_rsel = 5'd0;
`ifdef WB_FWD_EN
    logic        fwd_hit, fwd_hit2;
    logic [31:0] fwd_data, fwd_data2;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] log_q [$];
    logic [36:0] exp_bp [6];

    writeback_stage_mw #(.LANES(2), .WPORTS(1), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_wen(in_wen), .in_halt(in_halt), .in_wsel(in_wsel),
        .in_wdat(in_wdat), .in_ready(in_ready), .rf_wen(rf_wen),
        .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .halt(halt),
        .occupancy(occupancy)
`ifdef WB_FWD_EN
        , .fwd_rsel(fwd_rsel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    writeback_stage_mw #(.LANES(2), .WPORTS(2), .DEPTH(4)) dut2 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_wen(in_wen), .in_halt(in_halt), .in_wsel(in_wsel),
        .in_wdat(in_wdat), .in_ready(in_ready2), .rf_wen(rf_wen2),
        .rf_wsel(rf_wsel2), .rf_wdat(rf_wdat2), .halt(halt2),
        .occupancy(occ2)
`ifdef WB_FWD_EN
        , .fwd_rsel(fwd_rsel), .fwd_hit(fwd_hit2), .fwd_data(fwd_data2)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RST && rf_wen[0]) log_q.push_back({rf_wsel, rf_wdat});
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        ihit = 1'b1; dhit = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = '0; in_wen = '0; in_halt = '0;
        in_wsel = '0; in_wdat = '0;
    endtask

    task automatic offer(input logic [1:0] v, input logic [1:0] w,
                         input logic [1:0] h,
                         input logic [4:0] s0, input logic [31:0] d0,
                         input logic [4:0] s1, input logic [31:0] d1);
        in_valid = v; in_wen = w; in_halt = h;
        in_wsel = {s1, s0}; in_wdat = {d1, d0};
    endtask

    task automatic do_reset;
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        log_q.delete();
    endtask

    task automatic test_reset;
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        offer(2'b11, 2'b11, 2'b00, 5'd1, 32'ha1, 5'd2, 32'ha2);
        step();
        offer(2'b11, 2'b11, 2'b00, 5'd3, 32'hb3, 5'd4, 32'hb4);
        step();
        idle();
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre_occ got %0d want 3", occupancy);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL rst_wen_forced got %b want 0", rf_wen);
        end
        step();
        RST = 1'b0;
        #1;
        checks++;
        if (occupancy !== 3'd0 || halt !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_state got occ=%0d halt=%b rdy=%b want 0 0 1",
                     occupancy, halt, in_ready);
        end
        step();
        checks++;
        if (rf_wen !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL rst_discard got wen=%b occ=%0d want 0 0",
                     rf_wen, occupancy);
        end
        log_q.delete();
    endtask

    task automatic test_basic;
        do_reset();
        offer(2'b11, 2'b11, 2'b00, 5'd3, 32'h11, 5'd4, 32'h22);
        step();
        idle();
        checks++;
        if (occupancy !== 3'd2 || rf_wen !== 1'b1 ||
            rf_wsel !== 5'd3 || rf_wdat !== 32'h11) begin
            errors++;
            $display("FAIL basic_c1 got occ=%0d wen=%b sel=%0d dat=%h want 2 1 3 11",
                     occupancy, rf_wen, rf_wsel, rf_wdat);
        end
        step();
        checks++;
        if (occupancy !== 3'd1 || rf_wen !== 1'b1 ||
            rf_wsel !== 5'd4 || rf_wdat !== 32'h22) begin
            errors++;
            $display("FAIL basic_c2 got occ=%0d wen=%b sel=%0d dat=%h want 1 1 4 22",
                     occupancy, rf_wen, rf_wsel, rf_wdat);
        end
        step();
        checks++;
        if (occupancy !== 3'd0 || rf_wen !== 1'b0 || log_q.size() != 2) begin
            errors++;
            $display("FAIL basic_c3 got occ=%0d wen=%b writes=%0d want 0 0 2",
                     occupancy, rf_wen, log_q.size());
        end
    endtask

    task automatic test_back_pressure;
        exp_bp[0] = {5'd1, 32'hc1}; exp_bp[1] = {5'd2, 32'hc2};
        exp_bp[2] = {5'd3, 32'hc3}; exp_bp[3] = {5'd4, 32'hc4};
        exp_bp[4] = {5'd5, 32'hc5}; exp_bp[5] = {5'd6, 32'hc6};
        do_reset();
        offer(2'b11, 2'b11, 2'b00, 5'd1, 32'hc1, 5'd2, 32'hc2);
        step();
        offer(2'b11, 2'b11, 2'b00, 5'd3, 32'hc3, 5'd4, 32'hc4);
        step();
        checks++;
        if (occupancy !== 3'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rdy=%b want 3 0",
                     occupancy, in_ready);
        end
        offer(2'b11, 2'b11, 2'b00, 5'd5, 32'hc5, 5'd6, 32'hc6);
        step();
        checks++;
        if (occupancy !== 3'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reopen got occ=%0d rdy=%b want 2 1",
                     occupancy, in_ready);
        end
        step();
        idle();
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL bp_accept got occ=%0d want 3", occupancy);
        end
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) step();
        checks++;
        if (occupancy !== 3'd0 || log_q.size() != 6) begin
            errors++;
            $display("FAIL bp_drain got occ=%0d writes=%0d want 0 6",
                     occupancy, log_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i] !== exp_bp[i]) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h want %h", i,
                         (i < log_q.size()) ? log_q[i] : 37'h0, exp_bp[i]);
            end
        end
    endtask

    task automatic test_filter;
        do_reset();
        offer(2'b11, 2'b01, 2'b00, 5'd0, 32'h55, 5'd7, 32'h66);
        step();
        checks++;
        if (occupancy !== 3'd0 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL filt_r0_nowen got occ=%0d wen=%b want 0 0",
                     occupancy, rf_wen);
        end
        offer(2'b11, 2'b11, 2'b10, 5'd8, 32'h88, 5'd9, 32'h99);
        flush = 1'b1;
        step();
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL filt_flush got occ=%0d want 0", occupancy);
        end
        flush = 1'b0;
        ihit = 1'b0;
        step();
        ihit = 1'b1;
        stall = 1'b1;
        step();
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL filt_ihit_stall got occ=%0d want 0", occupancy);
        end
        stall = 1'b0;
        offer(2'b10, 2'b11, 2'b01, 5'd10, 32'haa, 5'd11, 32'hbb);
        step();
        idle();
        checks++;
        if (occupancy !== 3'd1 || rf_wsel !== 5'd11 || rf_wdat !== 32'hbb) begin
            errors++;
            $display("FAIL filt_invalid_lane got occ=%0d sel=%0d dat=%h want 1 11 bb",
                     occupancy, rf_wsel, rf_wdat);
        end
        step();
        step();
        checks++;
        if (halt !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL filt_no_halt got halt=%b occ=%0d want 0 0",
                     halt, occupancy);
        end
    endtask

    task automatic test_halt;
        do_reset();
        offer(2'b01, 2'b01, 2'b00, 5'd2, 32'h5, 5'd0, 32'h0);
        step();
        offer(2'b11, 2'b01, 2'b10, 5'd5, 32'h7, 5'd0, 32'h0);
        step();
        checks++;
        if (occupancy !== 3'd1 || rf_wsel !== 5'd5 ||
            rf_wdat !== 32'h7 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_pending got occ=%0d sel=%0d dat=%h halt=%b want 1 5 7 0",
                     occupancy, rf_wsel, rf_wdat, halt);
        end
        offer(2'b11, 2'b11, 2'b00, 5'd9, 32'h9, 5'd10, 32'h10);
        step();
        checks++;
        if (halt !== 1'b1 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL halt_rise got halt=%b occ=%0d want 1 0",
                     halt, occupancy);
        end
        step();
        idle();
        checks++;
        if (halt !== 1'b1 || occupancy !== 3'd0 || log_q.size() != 2) begin
            errors++;
            $display("FAIL halt_ignore got halt=%b occ=%0d writes=%0d want 1 0 2",
                     halt, occupancy, log_q.size());
        end
        do_reset();
        offer(2'b11, 2'b10, 2'b01, 5'd12, 32'h12, 5'd13, 32'h13);
        step();
        idle();
        checks++;
        if (occupancy !== 3'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_lane0_cut got occ=%0d halt=%b want 0 0",
                     occupancy, halt);
        end
        step();
        checks++;
        if (halt !== 1'b1 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL halt_lane0_rise got halt=%b wen=%b want 1 0",
                     halt, rf_wen);
        end
        do_reset();
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear got %b want 0", halt);
        end
    endtask

    task automatic test_waw;
        do_reset();
        offer(2'b11, 2'b11, 2'b00, 5'd6, 32'h1, 5'd6, 32'h2);
        step();
        idle();
        checks++;
        if (occ2 !== 3'd2 || rf_wen2 !== 2'b10 ||
            rf_wsel2[9:5] !== 5'd6 || rf_wdat2[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL waw_drain got occ=%0d wen=%b sel=%0d dat=%h want 2 10 6 2",
                     occ2, rf_wen2, rf_wsel2[9:5], rf_wdat2[63:32]);
        end
`ifdef WB_FWD_EN
        fwd_rsel = 5'd6;
        #1;
        checks++;
        if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h2) begin
            errors++;
            $display("FAIL fwd_hit got hit=%b dat=%h want 1 2",
                     fwd_hit2, fwd_data2);
        end
        fwd_rsel = 5'd7;
        #1;
        checks++;
        if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL fwd_miss got hit=%b dat=%h want 0 0",
                     fwd_hit2, fwd_data2);
        end
        fwd_rsel = 5'd0;
`endif
        step();
        checks++;
        if (occ2 !== 3'd0 || rf_wen2 !== 2'b00) begin
            errors++;
            $display("FAIL waw_pop got occ=%0d wen=%b want 0 00", occ2, rf_wen2);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_back_pressure();
        test_filter();
        test_halt();
        test_waw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
